vs0_dfx_ctrl: RTL and testbench

- Decoupling and sequencing controller between the crossbar and Virtual Socket 0 (VS0).
- Its job is to isolate VS0 safely while a Reconfigurable Module (RM) is swapped by partial reconfiguration.
- Normal operation: forwards the crossbar->VS0 Wishbone slave path, the VS0->crossbar Wishbone master path and the VS0 IRQ.
- On software request: drains in-flight traffic, isolates the socket, holds the RM in reset, and later re-couples it.
- Software control is through a small Wishbone register slave.

---
 rtl/vs0_dfx_ctrl_if.sv | 100 ++++++++++
 rtl/vs0_dfx_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_vs0_dfx_ctrl.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vs0_dfx_ctrl_if.sv
// Signal bundle around the VS0 decoupler: control register slave, crossbar<->VS0
// slave path, VS0<->crossbar master path, interrupt and RM reset.
interface vs0_dfx_ctrl_if;
    // Control register slave
    logic        ctl_adr;
    logic [31:0] ctl_dat_w;
    logic [3:0]  ctl_sel;
    logic        ctl_we;
    logic        ctl_cyc;
    logic        ctl_stb;
    logic [31:0] ctl_dat_r;
    logic        ctl_ack;
    logic        ctl_stall;
    logic        ctl_err;

    // Crossbar master port -> controller
    logic [17:0] xb_s_adr;
    logic [31:0] xb_s_dat_w;
    logic [3:0]  xb_s_sel;
    logic        xb_s_we;
    logic        xb_s_cyc;
    logic        xb_s_stb;
    logic [31:0] xb_s_dat_r;
    logic        xb_s_ack;
    logic        xb_s_stall;
    logic        xb_s_err;

    // Controller -> VS0 slave port
    logic [17:0] vs_s_adr;
    logic [31:0] vs_s_dat_w;
    logic [3:0]  vs_s_sel;
    logic        vs_s_we;
    logic        vs_s_cyc;
    logic        vs_s_stb;
    logic [31:0] vs_s_dat_r;
    logic        vs_s_ack;
    logic        vs_s_stall;
    logic        vs_s_err;

    // VS0 master port -> controller
    logic [27:0] vs_m_adr;
    logic [31:0] vs_m_dat_w;
    logic        vs_m_we;
    logic [3:0]  vs_m_sel;
    logic        vs_m_cyc;
    logic        vs_m_stb;
    logic [31:0] vs_m_dat_r;
    logic        vs_m_ack;
    logic        vs_m_stall;
    logic        vs_m_err;

    // Controller -> crossbar slave port
    logic [27:0] xb_m_adr;
    logic [31:0] xb_m_dat_w;
    logic        xb_m_we;
    logic [3:0]  xb_m_sel;
    logic        xb_m_cyc;
    logic        xb_m_stb;
    logic [31:0] xb_m_dat_r;
    logic        xb_m_ack;
    logic        xb_m_stall;
    logic        xb_m_err;

    // Interrupt and RM reset
    logic        vs_irq_in;
    logic        irq_out;
    logic        vs_rst;

    // Decoupler side
    modport slave (
        input  ctl_adr, ctl_dat_w, ctl_sel, ctl_we, ctl_cyc, ctl_stb,
        output ctl_dat_r, ctl_ack, ctl_stall, ctl_err,
        input  xb_s_adr, xb_s_dat_w, xb_s_sel, xb_s_we, xb_s_cyc, xb_s_stb,
        output xb_s_dat_r, xb_s_ack, xb_s_stall, xb_s_err,
        output vs_s_adr, vs_s_dat_w, vs_s_sel, vs_s_we, vs_s_cyc, vs_s_stb,
        input  vs_s_dat_r, vs_s_ack, vs_s_stall, vs_s_err,
        input  vs_m_adr, vs_m_dat_w, vs_m_we, vs_m_sel, vs_m_cyc, vs_m_stb,
        output vs_m_dat_r, vs_m_ack, vs_m_stall, vs_m_err,
        output xb_m_adr, xb_m_dat_w, xb_m_we, xb_m_sel, xb_m_cyc, xb_m_stb,
        input  xb_m_dat_r, xb_m_ack, xb_m_stall, xb_m_err,
        input  vs_irq_in,
        output irq_out, vs_rst
    );

    // Surrounding system side (software, crossbar and socket)
    modport master (
        output ctl_adr, ctl_dat_w, ctl_sel, ctl_we, ctl_cyc, ctl_stb,
        input  ctl_dat_r, ctl_ack, ctl_stall, ctl_err,
        output xb_s_adr, xb_s_dat_w, xb_s_sel, xb_s_we, xb_s_cyc, xb_s_stb,
        input  xb_s_dat_r, xb_s_ack, xb_s_stall, xb_s_err,
        input  vs_s_adr, vs_s_dat_w, vs_s_sel, vs_s_we, vs_s_cyc, vs_s_stb,
        output vs_s_dat_r, vs_s_ack, vs_s_stall, vs_s_err,
        output vs_m_adr, vs_m_dat_w, vs_m_we, vs_m_sel, vs_m_cyc, vs_m_stb,
        input  vs_m_dat_r, vs_m_ack, vs_m_stall, vs_m_err,
        input  xb_m_adr, xb_m_dat_w, xb_m_we, xb_m_sel, xb_m_cyc, xb_m_stb,
        output xb_m_dat_r, xb_m_ack, xb_m_stall, xb_m_err,
        output vs_irq_in,
        input  irq_out, vs_rst
    );
endinterface

// File: rtl/vs0_dfx_ctrl.sv
// Virtual Socket 0 decoupler: forwards crossbar/VS0 traffic while coupled, drains
// and isolates the socket (RM held in reset) around partial reconfiguration.
module vs0_dfx_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT  = 1024,
    parameter int unsigned RELEASE_CYCLES = 16,
    parameter int unsigned OUTST_W        = 4,
    parameter bit          INIT_DECOUPLED = 1'b0
) (
    input  logic          sys_clk,
    input  logic          rst,
    vs0_dfx_ctrl_if.slave bus
);

    // One timer serves both the drain timeout and the release hold-off
    localparam int unsigned TMR_MAX = (DRAIN_TIMEOUT > RELEASE_CYCLES) ? DRAIN_TIMEOUT : RELEASE_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_COUPLED   = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_DECOUPLED = 2'd2,
        ST_RELEASE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic               r_vs_rst;
    logic               r_timeout;
    logic [OUTST_W-1:0] r_outst;
    logic               r_xb_cyc_d;
    logic               r_dec_err;
    logic               r_ctrl_bit;
    logic               r_ctl_ack;
    logic [31:0]        r_ctl_dat_r;

    logic        w_coupled;
    logic        w_draining;
    logic        w_iso;
    logic        w_ctl_acc;
    logic        w_ctl_wr;
    logic        w_wr_ctrl;
    logic        w_dec_req;
    logic        w_rec_req;
    logic        w_clr_tmo;
    logic        w_inc;
    logic        w_dec;
    logic [3:0]  w_cnt4;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_coupled  = (r_state == ST_COUPLED);
    assign w_draining = (r_state == ST_DRAIN);
    assign w_iso      = (r_state == ST_DECOUPLED) || (r_state == ST_RELEASE);

    // Control register decode; requests act on the cycle the write is accepted
    assign w_ctl_acc = bus.ctl_cyc & bus.ctl_stb;
    assign w_ctl_wr  = w_ctl_acc & bus.ctl_we & bus.ctl_sel[0];
    assign w_wr_ctrl = w_ctl_wr & ~bus.ctl_adr;
    assign w_dec_req = w_wr_ctrl & bus.ctl_dat_w[0];
    assign w_rec_req = w_wr_ctrl & ~bus.ctl_dat_w[0];
    assign w_clr_tmo = w_ctl_wr & bus.ctl_adr & bus.ctl_dat_w[2];

    assign w_cnt4   = 4'(r_outst);
    assign w_status = {24'h0, w_cnt4, 1'b0, r_timeout, w_draining, w_iso};

    // Bits of the control write data that carry no meaning
    assign w_unused = ^{bus.ctl_dat_w[31:3], bus.ctl_dat_w[1], bus.ctl_sel[3:1]};

    // Control slave: single-cycle registered response, never stalls or errors
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_ctl_ack   <= 1'b0;
            r_ctl_dat_r <= 32'h0;
            r_ctrl_bit  <= INIT_DECOUPLED;
        end else begin
            r_ctl_ack <= w_ctl_acc;
            if (w_ctl_acc && !bus.ctl_we) begin
                r_ctl_dat_r <= bus.ctl_adr ? w_status : {31'h0, r_ctrl_bit};
            end else begin
                r_ctl_dat_r <= 32'h0;
            end
            if (w_wr_ctrl) begin
                r_ctrl_bit <= bus.ctl_dat_w[0];
            end
        end
    end

    assign bus.ctl_ack   = r_ctl_ack;
    assign bus.ctl_dat_r = r_ctl_dat_r;
    assign bus.ctl_stall = 1'b0;
    assign bus.ctl_err   = 1'b0;

    // Outstanding slave requests issued to VS0 and not yet answered
    assign w_inc = bus.vs_s_cyc & bus.vs_s_stb & ~bus.vs_s_stall;
    assign w_dec = bus.vs_s_ack | bus.vs_s_err;

    // Saturating outstanding counter, flushed when the crossbar ends its cycle
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_outst    <= '0;
            r_xb_cyc_d <= 1'b0;
        end else begin
            r_xb_cyc_d <= bus.xb_s_cyc;
            if (r_xb_cyc_d && !bus.xb_s_cyc) begin
                r_outst <= '0;
            end else if (w_inc && !w_dec && (r_outst != '1)) begin
                r_outst <= r_outst + OUTST_W'(1);
            end else if (w_dec && !w_inc && (r_outst != '0)) begin
                r_outst <= r_outst - OUTST_W'(1);
            end
        end
    end

    // Error reply, one cycle late, for every crossbar strobe hitting an isolated socket
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_dec_err <= 1'b0;
        end else begin
            r_dec_err <= w_iso & bus.xb_s_cyc & bus.xb_s_stb;
        end
    end

    // Coupling state machine with registered RM reset and sticky timeout flag
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            if (INIT_DECOUPLED) begin
                r_state <= ST_DECOUPLED;
            end else begin
                r_state <= ST_COUPLED;
            end
            r_timer   <= '0;
            r_vs_rst  <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            if (w_clr_tmo) begin
                r_timeout <= 1'b0;
            end
            case (r_state)
                ST_COUPLED: begin
                    r_vs_rst <= 1'b0;
                    if (w_dec_req) begin
                        r_state <= ST_DRAIN;
                        r_timer <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_rec_req) begin
                        r_state <= ST_COUPLED;
                    end else if ((r_outst == '0) && !bus.vs_m_cyc) begin
                        r_state  <= ST_DECOUPLED;
                        r_vs_rst <= 1'b1;
                    end else if (r_timer == TMR_W'(DRAIN_TIMEOUT - 1)) begin
                        // Socket refused to go quiet: cut it off anyway and flag it
                        r_state   <= ST_DECOUPLED;
                        r_vs_rst  <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_DECOUPLED: begin
                    r_vs_rst <= 1'b1;
                    if (w_rec_req) begin
                        r_state <= ST_RELEASE;
                        r_timer <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (w_dec_req) begin
                        r_state  <= ST_DECOUPLED;
                        r_vs_rst <= 1'b1;
                    end else if (r_vs_rst) begin
                        if (r_timer == TMR_W'(RELEASE_CYCLES - 1)) begin
                            r_vs_rst <= 1'b0;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end else begin
                        // RM has had one isolated cycle out of reset; open the paths
                        r_state <= ST_COUPLED;
                    end
                end
                default: begin
                    r_state <= ST_COUPLED;
                end
            endcase
        end
    end

    assign bus.vs_rst = r_vs_rst;

    // Crossbar -> VS0 slave request path: no new strobes unless coupled
    assign bus.vs_s_adr   = bus.xb_s_adr;
    assign bus.vs_s_dat_w = bus.xb_s_dat_w;
    assign bus.vs_s_sel   = bus.xb_s_sel;
    assign bus.vs_s_we    = bus.xb_s_we;
    assign bus.vs_s_cyc   = bus.xb_s_cyc & ~w_iso;
    assign bus.vs_s_stb   = bus.xb_s_stb & w_coupled;

    // VS0 -> crossbar slave response path: drained responses still flow back
    assign bus.xb_s_dat_r = w_iso ? 32'h0 : bus.vs_s_dat_r;
    assign bus.xb_s_ack   = ~w_iso & bus.vs_s_ack;
    assign bus.xb_s_stall = w_draining | (w_coupled & bus.vs_s_stall);
    assign bus.xb_s_err   = r_dec_err | (~w_iso & bus.vs_s_err);

    // VS0 -> crossbar master path: an isolated master cycle is aborted by dropping cyc
    assign bus.xb_m_adr   = bus.vs_m_adr;
    assign bus.xb_m_dat_w = bus.vs_m_dat_w;
    assign bus.xb_m_sel   = bus.vs_m_sel;
    assign bus.xb_m_we    = bus.vs_m_we & ~w_iso;
    assign bus.xb_m_cyc   = bus.vs_m_cyc & ~w_iso;
    assign bus.xb_m_stb   = bus.vs_m_stb & ~w_iso;

    // Crossbar -> VS0 master response path: stalled forever while isolated
    assign bus.vs_m_dat_r = w_iso ? 32'h0 : bus.xb_m_dat_r;
    assign bus.vs_m_ack   = ~w_iso & bus.xb_m_ack;
    assign bus.vs_m_err   = ~w_iso & bus.xb_m_err;
    assign bus.vs_m_stall = w_iso | bus.xb_m_stall;

    // Interrupt is masked whenever the socket is isolated
    assign bus.irq_out = ~w_iso & bus.vs_irq_in;

endmodule

// File: tb/tb_vs0_dfx_ctrl.sv
// Self-checking bench for the VS0 decoupler: directed scenarios plus randomized
// traffic compared against a behavioural model of the coupling rules.
module tb_vs0_dfx_ctrl;

    localparam int unsigned DRAIN_TO = 8;
    localparam int unsigned REL_CYC  = 16;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    vs0_dfx_ctrl_if bus();

    vs0_dfx_ctrl #(
        .DRAIN_TIMEOUT (DRAIN_TO),
        .RELEASE_CYCLES(REL_CYC),
        .OUTST_W       (4),
        .INIT_DECOUPLED(1'b0)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // Safety net so the run always terminates
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.ctl_adr = 1'b0; bus.ctl_dat_w = 32'h0; bus.ctl_sel = 4'h0;
        bus.ctl_we = 1'b0; bus.ctl_cyc = 1'b0; bus.ctl_stb = 1'b0;
        bus.xb_s_adr = 18'h0; bus.xb_s_dat_w = 32'h0; bus.xb_s_sel = 4'h0;
        bus.xb_s_we = 1'b0; bus.xb_s_cyc = 1'b0; bus.xb_s_stb = 1'b0;
        bus.vs_s_dat_r = 32'h0; bus.vs_s_ack = 1'b0; bus.vs_s_stall = 1'b0; bus.vs_s_err = 1'b0;
        bus.vs_m_adr = 28'h0; bus.vs_m_dat_w = 32'h0; bus.vs_m_we = 1'b0;
        bus.vs_m_sel = 4'h0; bus.vs_m_cyc = 1'b0; bus.vs_m_stb = 1'b0;
        bus.xb_m_dat_r = 32'h0; bus.xb_m_ack = 1'b0; bus.xb_m_stall = 1'b0; bus.xb_m_err = 1'b0;
        bus.vs_irq_in = 1'b0;
    endtask

    // Control-port write; returns on the falling edge after the write edge
    task automatic ctl_write(input logic adr, input logic [31:0] dat, output logic ack);
        @(negedge sys_clk);
        bus.ctl_adr = adr; bus.ctl_dat_w = dat; bus.ctl_sel = 4'hf;
        bus.ctl_we = 1'b1; bus.ctl_cyc = 1'b1; bus.ctl_stb = 1'b1;
        @(negedge sys_clk);
        ack = bus.ctl_ack;
        bus.ctl_we = 1'b0; bus.ctl_cyc = 1'b0; bus.ctl_stb = 1'b0;
    endtask

    // Control-port read; value reflects the state at the sampling edge
    task automatic ctl_read(input logic adr, output logic [31:0] dat, output logic ack);
        @(negedge sys_clk);
        bus.ctl_adr = adr; bus.ctl_sel = 4'hf;
        bus.ctl_we = 1'b0; bus.ctl_cyc = 1'b1; bus.ctl_stb = 1'b1;
        @(negedge sys_clk);
        ack = bus.ctl_ack;
        dat = bus.ctl_dat_r;
        bus.ctl_cyc = 1'b0; bus.ctl_stb = 1'b0;
    endtask

    // Expected STATUS word built from the register's field definitions
    function automatic logic [31:0] status_word(bit decoupled, bit draining, bit tmo, int cnt);
        logic [31:0] w;
        w = 32'h0;
        w[0] = decoupled;
        w[1] = draining;
        w[2] = tmo;
        w[7:4] = 4'(cnt);
        return w;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        logic        a;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        n_checks++;
        if ({bus.vs_rst, bus.ctl_ack, bus.ctl_err, bus.ctl_stall} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_outputs: got vs_rst/ack/err/stall=%b required 1000",
                     {bus.vs_rst, bus.ctl_ack, bus.ctl_err, bus.ctl_stall});
        end
        n_checks++;
        if (bus.ctl_dat_r !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_dat_r: got %h required %h", bus.ctl_dat_r, 32'h0);
        end
        rst = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (bus.vs_rst !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_coupled_vs_rst: got %b required 0", bus.vs_rst);
        end
        ctl_read(1'b1, d, a);
        n_checks++;
        if ({a, d} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_status: got ack=%b dat=%h required ack=1 dat=%h", a, d, 32'h0);
        end
        ctl_read(1'b0, d, a);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %h required %h", d, 32'h0);
        end
    endtask

    task automatic test_passthrough();
        @(negedge sys_clk);
        bus.xb_s_cyc = 1'b1; bus.xb_s_stb = 1'b1; bus.xb_s_adr = 18'h2a5c4;
        bus.vs_s_dat_r = 32'h0000510b; bus.vs_s_ack = 1'b1; bus.vs_irq_in = 1'b1;
        #1;
        n_checks++;
        if ({bus.xb_s_dat_r, bus.xb_s_ack} !== {32'h0000510b, 1'b1}) begin
            n_errors++;
            $display("FAIL pass_read: got dat=%h ack=%b required dat=%h ack=1",
                     bus.xb_s_dat_r, bus.xb_s_ack, 32'h0000510b);
        end
        n_checks++;
        if ({bus.vs_s_stb, bus.vs_s_adr, bus.irq_out} !== {1'b1, 18'h2a5c4, 1'b1}) begin
            n_errors++;
            $display("FAIL pass_req_irq: got stb=%b adr=%h irq=%b required stb=1 adr=2a5c4 irq=1",
                     bus.vs_s_stb, bus.vs_s_adr, bus.irq_out);
        end
        @(negedge sys_clk);
        idle_inputs();
        @(negedge sys_clk);
    endtask

    // Random traffic; model: coupled = wires, isolated = fixed idle/err values
    task automatic test_random_traffic(input bit iso, input int iters);
        bit prev_strobe;
        logic [56:0] exp_vs_s;
        logic [34:0] exp_xb_s;
        logic [66:0] exp_xb_m;
        logic [34:0] exp_vs_m;
        logic [3:0]  exp_misc;
        prev_strobe = 1'b0;
        @(negedge sys_clk);
        bus.xb_s_stb = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < iters; i++) begin
            bus.xb_s_adr = 18'($urandom); bus.xb_s_dat_w = $urandom; bus.xb_s_sel = 4'($urandom);
            bus.xb_s_we = 1'($urandom); bus.xb_s_cyc = 1'($urandom); bus.xb_s_stb = 1'($urandom);
            bus.vs_s_dat_r = $urandom; bus.vs_s_ack = 1'($urandom);
            bus.vs_s_stall = 1'($urandom); bus.vs_s_err = 1'($urandom);
            bus.vs_m_adr = 28'($urandom); bus.vs_m_dat_w = $urandom; bus.vs_m_we = 1'($urandom);
            bus.vs_m_sel = 4'($urandom); bus.vs_m_cyc = 1'($urandom); bus.vs_m_stb = 1'($urandom);
            bus.xb_m_dat_r = $urandom; bus.xb_m_ack = 1'($urandom);
            bus.xb_m_stall = 1'($urandom); bus.xb_m_err = 1'($urandom);
            bus.vs_irq_in = 1'($urandom);
            #1;
            if (!iso) begin
                exp_vs_s = {bus.xb_s_adr, bus.xb_s_dat_w, bus.xb_s_sel, bus.xb_s_we, bus.xb_s_cyc, bus.xb_s_stb};
                exp_xb_s = {bus.vs_s_dat_r, bus.vs_s_ack, bus.vs_s_stall, bus.vs_s_err};
                exp_xb_m = {bus.vs_m_adr, bus.vs_m_dat_w, bus.vs_m_we, bus.vs_m_sel, bus.vs_m_cyc, bus.vs_m_stb};
                exp_vs_m = {bus.xb_m_dat_r, bus.xb_m_ack, bus.xb_m_stall, bus.xb_m_err};
                exp_misc = {bus.vs_irq_in, 1'b0, 2'b00};
                n_checks++;
                if ({bus.vs_s_adr, bus.vs_s_dat_w, bus.vs_s_sel, bus.vs_s_we, bus.vs_s_cyc, bus.vs_s_stb} !== exp_vs_s) begin
                    n_errors++;
                    $display("FAIL rand_vs_s[%0d]: got %h required %h", i,
                             {bus.vs_s_adr, bus.vs_s_dat_w, bus.vs_s_sel, bus.vs_s_we, bus.vs_s_cyc, bus.vs_s_stb}, exp_vs_s);
                end
                n_checks++;
                if ({bus.xb_m_adr, bus.xb_m_dat_w, bus.xb_m_we, bus.xb_m_sel, bus.xb_m_cyc, bus.xb_m_stb} !== exp_xb_m) begin
                    n_errors++;
                    $display("FAIL rand_xb_m[%0d]: got %h required %h", i,
                             {bus.xb_m_adr, bus.xb_m_dat_w, bus.xb_m_we, bus.xb_m_sel, bus.xb_m_cyc, bus.xb_m_stb}, exp_xb_m);
                end
            end else begin
                exp_xb_s = {32'h0, 1'b0, 1'b0, prev_strobe};
                exp_vs_m = {32'h0, 1'b0, 1'b1, 1'b0};
                exp_misc = {1'b0, 1'b1, 2'b00};
                n_checks++;
                if ({bus.vs_s_cyc, bus.vs_s_stb, bus.xb_m_cyc, bus.xb_m_stb, bus.xb_m_we} !== 5'b00000) begin
                    n_errors++;
                    $display("FAIL rand_iso_req[%0d]: got %b required 00000", i,
                             {bus.vs_s_cyc, bus.vs_s_stb, bus.xb_m_cyc, bus.xb_m_stb, bus.xb_m_we});
                end
            end
            n_checks++;
            if ({bus.xb_s_dat_r, bus.xb_s_ack, bus.xb_s_stall, bus.xb_s_err} !== exp_xb_s) begin
                n_errors++;
                $display("FAIL rand_xb_s_resp[%0d]: got %h required %h", i,
                         {bus.xb_s_dat_r, bus.xb_s_ack, bus.xb_s_stall, bus.xb_s_err}, exp_xb_s);
            end
            n_checks++;
            if ({bus.vs_m_dat_r, bus.vs_m_ack, bus.vs_m_stall, bus.vs_m_err} !== exp_vs_m) begin
                n_errors++;
                $display("FAIL rand_vs_m_resp[%0d]: got %h required %h", i,
                         {bus.vs_m_dat_r, bus.vs_m_ack, bus.vs_m_stall, bus.vs_m_err}, exp_vs_m);
            end
            n_checks++;
            if ({bus.irq_out, bus.vs_rst, 2'b00} !== exp_misc) begin
                n_errors++;
                $display("FAIL rand_irq_rst[%0d]: got irq/vs_rst=%b%b required %b%b", i,
                         bus.irq_out, bus.vs_rst, exp_misc[3], exp_misc[2]);
            end
            prev_strobe = bus.xb_s_cyc & bus.xb_s_stb;
            @(negedge sys_clk);
        end
        idle_inputs();
        repeat (2) @(negedge sys_clk);
    endtask

    // Outstanding-count behaviour under random issue/response mixes, with saturation
    task automatic test_outstanding_counter();
        int          m_cnt;
        int          pct [3];
        bit          inc;
        bit          dec;
        logic [31:0] d;
        logic        a;
        pct[0] = 90; pct[1] = 50; pct[2] = 15;
        m_cnt = 0;
        @(negedge sys_clk);
        bus.xb_s_cyc = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 24; c++) begin
                bus.xb_s_stb   = ($urandom_range(99) < pct[r]);
                bus.vs_s_stall = ($urandom_range(3) == 0);
                bus.vs_s_ack   = ($urandom_range(99) < (100 - pct[r]));
                bus.vs_s_err   = ($urandom_range(9) == 0);
                inc = bus.xb_s_stb && !bus.vs_s_stall;
                dec = bus.vs_s_ack || bus.vs_s_err;
                if (inc && !dec) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
                if (dec && !inc) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
                @(negedge sys_clk);
            end
            bus.xb_s_stb = 1'b0; bus.vs_s_ack = 1'b0; bus.vs_s_err = 1'b0; bus.vs_s_stall = 1'b0;
            ctl_read(1'b1, d, a);
            n_checks++;
            if (d !== status_word(1'b0, 1'b0, 1'b0, m_cnt)) begin
                n_errors++;
                $display("FAIL outst_round%0d: got %h required %h", r, d, status_word(1'b0, 1'b0, 1'b0, m_cnt));
            end
        end
        bus.xb_s_cyc = 1'b0;
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL outst_clear_on_cyc_fall: got %h required %h", d, 32'h0);
        end
    endtask

    task automatic test_clean_drain();
        logic [31:0] d;
        logic        a;
        @(negedge sys_clk);
        bus.xb_s_cyc = 1'b1; bus.xb_s_stb = 1'b1;
        repeat (3) @(negedge sys_clk);
        bus.xb_s_stb = 1'b0; bus.vs_m_cyc = 1'b1;
        ctl_write(1'b0, 32'h1, a);
        n_checks++;
        if (a !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_ctl_ack: got %b required 1", a);
        end
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== status_word(1'b0, 1'b1, 1'b0, 3)) begin
            n_errors++;
            $display("FAIL drain_status: got %h required %h", d, status_word(1'b0, 1'b1, 1'b0, 3));
        end
        bus.xb_s_stb = 1'b1;
        #1;
        n_checks++;
        if ({bus.xb_s_stall, bus.vs_s_stb, bus.xb_m_cyc} !== 3'b101) begin
            n_errors++;
            $display("FAIL drain_blocking: got stall/vs_stb/xb_m_cyc=%b required 101",
                     {bus.xb_s_stall, bus.vs_s_stb, bus.xb_m_cyc});
        end
        bus.xb_s_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.vs_s_ack = 1'b1;
            #1;
            n_checks++;
            if (bus.xb_s_ack !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_ack_pass[%0d]: got %b required 1", i, bus.xb_s_ack);
            end
            @(negedge sys_clk);
        end
        bus.vs_s_ack = 1'b0; bus.vs_m_cyc = 1'b0;
        n_checks++;
        if (bus.vs_rst !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_rm_running: got vs_rst=%b required 0", bus.vs_rst);
        end
        @(negedge sys_clk);
        n_checks++;
        if ({bus.vs_rst, bus.vs_s_cyc} !== 2'b10) begin
            n_errors++;
            $display("FAIL drain_done_iso: got vs_rst/vs_s_cyc=%b required 10", {bus.vs_rst, bus.vs_s_cyc});
        end
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== 32'h1) begin
            n_errors++;
            $display("FAIL drain_final_status: got %h required %h", d, 32'h1);
        end
        idle_inputs();
    endtask

    task automatic test_decoupled_access();
        @(negedge sys_clk);
        bus.xb_s_cyc = 1'b1; bus.xb_s_stb = 1'b1; bus.vs_s_ack = 1'b1; bus.vs_irq_in = 1'b1;
        bus.vs_m_cyc = 1'b1; bus.vs_m_stb = 1'b1; bus.vs_m_we = 1'b1;
        #1;
        n_checks++;
        if ({bus.vs_s_cyc, bus.vs_s_stb, bus.xb_s_ack, bus.xb_s_err, bus.irq_out} !== 5'b00000) begin
            n_errors++;
            $display("FAIL dec_first_cycle: got vs_cyc/vs_stb/ack/err/irq=%b required 00000",
                     {bus.vs_s_cyc, bus.vs_s_stb, bus.xb_s_ack, bus.xb_s_err, bus.irq_out});
        end
        n_checks++;
        if ({bus.xb_m_cyc, bus.xb_m_stb, bus.xb_m_we, bus.vs_m_stall} !== 4'b0001) begin
            n_errors++;
            $display("FAIL dec_master_iso: got %b required 0001",
                     {bus.xb_m_cyc, bus.xb_m_stb, bus.xb_m_we, bus.vs_m_stall});
        end
        @(negedge sys_clk);
        bus.xb_s_stb = 1'b0;
        #1;
        n_checks++;
        if ({bus.xb_s_err, bus.vs_s_stb} !== 2'b10) begin
            n_errors++;
            $display("FAIL dec_err_next_cycle: got err/vs_stb=%b required 10", {bus.xb_s_err, bus.vs_s_stb});
        end
        @(negedge sys_clk);
        n_checks++;
        if (bus.xb_s_err !== 1'b0) begin
            n_errors++;
            $display("FAIL dec_err_single: got %b required 0", bus.xb_s_err);
        end
        idle_inputs();
    endtask

    task automatic test_recouple();
        logic a;
        bit   exp_rst;
        bit   exp_iso;
        ctl_write(1'b0, 32'h0, a);
        for (int k = 0; k < int'(REL_CYC) + 2; k++) begin
            exp_rst = (k < int'(REL_CYC));
            exp_iso = (k < int'(REL_CYC) + 1);
            n_checks++;
            if ({bus.vs_rst, bus.vs_m_stall} !== {exp_rst, exp_iso}) begin
                n_errors++;
                $display("FAIL recouple_cycle%0d: got vs_rst/vs_m_stall=%b%b required %b%b",
                         k, bus.vs_rst, bus.vs_m_stall, exp_rst, exp_iso);
            end
            @(negedge sys_clk);
        end
        bus.xb_s_cyc = 1'b1; bus.xb_s_stb = 1'b1;
        bus.vs_s_dat_r = 32'hcafe0042; bus.vs_s_ack = 1'b1;
        #1;
        n_checks++;
        if ({bus.xb_s_ack, bus.xb_s_err, bus.xb_s_dat_r} !== {1'b1, 1'b0, 32'hcafe0042}) begin
            n_errors++;
            $display("FAIL recouple_read: got ack=%b err=%b dat=%h required ack=1 err=0 dat=cafe0042",
                     bus.xb_s_ack, bus.xb_s_err, bus.xb_s_dat_r);
        end
        @(negedge sys_clk);
        idle_inputs();
        @(negedge sys_clk);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic        a;
        @(negedge sys_clk);
        bus.vs_m_cyc = 1'b1; bus.vs_m_stb = 1'b1;
        ctl_write(1'b0, 32'h1, a);
        for (int k = 0; k < int'(DRAIN_TO) + 2; k++) begin
            n_checks++;
            if (bus.xb_m_cyc !== 1'(k < int'(DRAIN_TO))) begin
                n_errors++;
                $display("FAIL timeout_cycle%0d: got xb_m_cyc=%b required %b", k, bus.xb_m_cyc, k < int'(DRAIN_TO));
            end
            @(negedge sys_clk);
        end
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== 32'h5) begin
            n_errors++;
            $display("FAIL timeout_status: got %h required %h", d, 32'h5);
        end
        bus.vs_m_cyc = 1'b0; bus.vs_m_stb = 1'b0;
        ctl_write(1'b1, 32'h4, a);
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== 32'h1) begin
            n_errors++;
            $display("FAIL timeout_clear: got %h required %h", d, 32'h1);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] d;
        logic        a;
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        bus.xb_s_cyc = 1'b1; bus.xb_s_stb = 1'b1;
        repeat (2) @(negedge sys_clk);
        bus.xb_s_stb = 1'b0; bus.vs_m_cyc = 1'b1;
        ctl_write(1'b0, 32'h1, a);
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== status_word(1'b0, 1'b1, 1'b0, 2)) begin
            n_errors++;
            $display("FAIL rstdrain_pre: got %h required %h", d, status_word(1'b0, 1'b1, 1'b0, 2));
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.vs_rst !== 1'b1) begin
            n_errors++;
            $display("FAIL rstdrain_vs_rst_during: got %b required 1", bus.vs_rst);
        end
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if ({bus.vs_rst, bus.xb_s_stall, bus.xb_m_cyc} !== 3'b001) begin
            n_errors++;
            $display("FAIL rstdrain_coupled: got vs_rst/stall/xb_m_cyc=%b required 001",
                     {bus.vs_rst, bus.xb_s_stall, bus.xb_m_cyc});
        end
        ctl_read(1'b1, d, a);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL rstdrain_status: got %h required %h", d, 32'h0);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_passthrough();
        test_random_traffic(1'b0, 24);
        test_outstanding_counter();
        test_clean_drain();
        test_decoupled_access();
        test_recouple();
        test_timeout();
        test_random_traffic(1'b1, 16);
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
